// File: rtl/sys_bridge_if.sv
// sys_bridge_if: CPU data-port handshake between the CPU (master) and sys_bridge (slave).
//   cpu_req/cpu_we/cpu_addr/cpu_wd : request side, held stable by the CPU until cpu_ack
//   cpu_rd/cpu_ack/cpu_err         : response side, driven by the bridge
interface sys_bridge_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic [31:0] cpu_rd;
  logic        cpu_ack;
  logic        cpu_err;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wd,
    input  cpu_rd, cpu_ack, cpu_err
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd,
    output cpu_rd, cpu_ack, cpu_err
  );
endinterface

// File: rtl/sys_bridge.sv
// sys_bridge: bus initiator between the CPU data port and two memory-mapped timers,
// plus a local IRQ mask register and the registered HWInt vector.
//
// Ports
//   clk, reset_n       : clock, asynchronous active-low reset
//   cpu (slave)        : CPU request/response handshake (see sys_bridge_if)
//   DEV_Addr, DEV_WD   : shared device address / write data (latched request)
//   DEV0_WE, DEV1_WE   : one-cycle write strobes
//   DEV0_RD, DEV1_RD   : combinational device read data
//   irq_in, hwint      : level interrupts in, masked and registered interrupts out
//
// Optional feature: define BRIDGE_BUSERR_EN to flag unmapped accesses on cpu_err.
// Without it cpu_err stays 0; timing is identical either way.
//
// Every access takes the same path: request sampled in IDLE, device driven in ACCESS,
// ack in RESP. Address map: DEV0 / DEV1 / local, 16-byte windows each.
//
// state  | meaning
// IDLE   | waiting for cpu_req; latches address, data, direction and decode
// ACCESS | latched address/data on the device bus; write strobe or read capture
// RESP   | cpu_ack (and cpu_err) pulse for one cycle
module sys_bridge #(
  parameter logic [31:0] DEV0_BASE   = 32'h0000_7F00,
  parameter logic [31:0] DEV1_BASE   = 32'h0000_7F10,
  parameter logic [31:0] BRIDGE_BASE = 32'h0000_7F20,
  parameter int          N_IRQ       = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  sys_bridge_if.slave      cpu,
  output logic [31:0]      DEV_Addr,
  output logic [31:0]      DEV_WD,
  output logic             DEV0_WE,
  output logic             DEV1_WE,
  input  logic [31:0]      DEV0_RD,
  input  logic [31:0]      DEV1_RD,
  input  logic [N_IRQ-1:0] irq_in,
  output logic [N_IRQ-1:0] hwint
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_DEV0  = 2'd1,
    SEL_DEV1  = 2'd2,
    SEL_LOCAL = 2'd3
  } sel_t;

  state_t            state_q, state_d;
  sel_t              sel_q, sel_d;
  sel_t              sel_in;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wd_q, wd_d;
  logic              dev0_we_q, dev0_we_d;
  logic              dev1_we_q, dev1_we_d;
  logic [31:0]       rd_q, rd_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [N_IRQ-1:0]  mask_q, mask_d;
  logic [N_IRQ-1:0]  hwint_q, hwint_d;
  logic [31:0]       local_rd;
  logic [31:0]       sel_rd;

  // Address decode on the live request; only the upper 28 bits pick the window.
  always_comb begin
    sel_in = SEL_NONE;
    if (cpu.cpu_addr[31:4] == DEV0_BASE[31:4]) begin
      sel_in = SEL_DEV0;
    end else if (cpu.cpu_addr[31:4] == DEV1_BASE[31:4]) begin
      sel_in = SEL_DEV1;
    end else if (cpu.cpu_addr[31:4] == BRIDGE_BASE[31:4]) begin
      sel_in = SEL_LOCAL;
    end
  end

  // Local register read mux: +0 mask, +4 raw irq_in, +8/+C read zero.
  always_comb begin
    local_rd = '0;
    case (addr_q[3:2])
      2'd0:    local_rd[N_IRQ-1:0] = mask_q;
      2'd1:    local_rd[N_IRQ-1:0] = irq_in;
      default: local_rd = '0;
    endcase
  end

  always_comb begin
    sel_rd = '0;
    case (sel_q)
      SEL_DEV0:  sel_rd = DEV0_RD;
      SEL_DEV1:  sel_rd = DEV1_RD;
      SEL_LOCAL: sel_rd = local_rd;
      default:   sel_rd = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wd_d      = wd_q;
    dev0_we_d = 1'b0;
    dev1_we_d = 1'b0;
    rd_d      = rd_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    mask_d    = mask_q;
    hwint_d   = irq_in & mask_q;

    case (state_q)
      IDLE: begin
        if (cpu.cpu_req) begin
          sel_d     = sel_in;
          we_d      = cpu.cpu_we;
          addr_d    = cpu.cpu_addr;
          wd_d      = cpu.cpu_wd;
          // Strobes are registered here so they are high for exactly the ACCESS cycle.
          dev0_we_d = cpu.cpu_we && (sel_in == SEL_DEV0);
          dev1_we_d = cpu.cpu_we && (sel_in == SEL_DEV1);
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          rd_d = sel_rd;
        end else if ((sel_q == SEL_LOCAL) && (addr_q[3:2] == 2'd0)) begin
          mask_d = wd_q[N_IRQ-1:0];
        end
        ack_d = 1'b1;
`ifdef BRIDGE_BUSERR_EN
        err_d = (sel_q == SEL_NONE);
`else
        err_d = 1'b0;
`endif
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sel_q     <= SEL_NONE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wd_q      <= '0;
      dev0_we_q <= 1'b0;
      dev1_we_q <= 1'b0;
      rd_q      <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      mask_q    <= '1;
      hwint_q   <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wd_q      <= wd_d;
      dev0_we_q <= dev0_we_d;
      dev1_we_q <= dev1_we_d;
      rd_q      <= rd_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      mask_q    <= mask_d;
      hwint_q   <= hwint_d;
    end
  end

  assign cpu.cpu_rd  = rd_q;
  assign cpu.cpu_ack = ack_q;
  assign cpu.cpu_err = err_q;
  assign DEV_Addr    = addr_q;
  assign DEV_WD      = wd_q;
  assign DEV0_WE     = dev0_we_q;
  assign DEV1_WE     = dev1_we_q;
  assign hwint       = hwint_q;

endmodule

// File: tb/tb_sys_bridge.sv
module tb_sys_bridge;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] dev_addr, dev_wd, dev0_rd, dev1_rd;
  logic        dev0_we, dev1_we;
  logic [5:0]  irq_in, hwint;

  always #5 clk = ~clk;

  sys_bridge_if bus ();

  sys_bridge dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu      (bus),
    .DEV_Addr (dev_addr),
    .DEV_WD   (dev_wd),
    .DEV0_WE  (dev0_we),
    .DEV1_WE  (dev1_we),
    .DEV0_RD  (dev0_rd),
    .DEV1_RD  (dev1_rd),
    .irq_in   (irq_in),
    .hwint    (hwint)
  );

`ifdef BRIDGE_BUSERR_EN
  localparam bit BUSERR = 1'b1;
`else
  localparam bit BUSERR = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted request at edge a puts its strobe in the cycle
  // after edge a, acks in the cycle after edge a+1, and blocks new requests until edge a+3.
  // Target kinds: 0 unmapped, 1 timer 0, 2 timer 1, 3 local registers.
  int          cyc;
  int          acc;
  logic        acc_we;
  logic [1:0]  acc_kind;
  logic [31:0] m_addr, m_wd, m_rd;
  logic [5:0]  m_mask, m_hw;

  function automatic logic [1:0] kind_of(input logic [31:0] a);
    if (a[31:4] == 28'h00007F0) return 2'd1;
    if (a[31:4] == 28'h00007F1) return 2'd2;
    if (a[31:4] == 28'h00007F2) return 2'd3;
    return 2'd0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc      <= 0;
      acc      <= -10;
      acc_we   <= 1'b0;
      acc_kind <= 2'd0;
      m_addr   <= '0;
      m_wd     <= '0;
      m_rd     <= '0;
      m_mask   <= 6'h3F;
      m_hw     <= '0;
    end else begin
      cyc  <= cyc + 1;
      m_hw <= irq_in & m_mask;
      if (cyc == acc) begin
        if (!acc_we) begin
          case (acc_kind)
            2'd1: m_rd <= dev0_rd;
            2'd2: m_rd <= dev1_rd;
            2'd3: m_rd <= (m_addr[3:2] == 2'd0) ? {26'd0, m_mask} :
                          (m_addr[3:2] == 2'd1) ? {26'd0, irq_in} : 32'd0;
            default: m_rd <= 32'd0;
          endcase
        end else if (acc_kind == 2'd3 && m_addr[3:2] == 2'd0) begin
          m_mask <= m_wd[5:0];
        end
      end
      if (bus.cpu_req && (cyc + 1 >= acc + 3)) begin
        acc      <= cyc + 1;
        acc_we   <= bus.cpu_we;
        acc_kind <= kind_of(bus.cpu_addr);
        m_addr   <= bus.cpu_addr;
        m_wd     <= bus.cpu_wd;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("m_ack", bus.cpu_ack, 32'(cyc == acc + 1));
      chk("m_err", bus.cpu_err, 32'((cyc == acc + 1) && acc_kind == 2'd0 && BUSERR));
      chk("m_we0", dev0_we, 32'((cyc == acc) && acc_we && acc_kind == 2'd1));
      chk("m_we1", dev1_we, 32'((cyc == acc) && acc_we && acc_kind == 2'd2));
      chk("m_dev_addr", dev_addr, m_addr);
      chk("m_dev_wd", dev_wd, m_wd);
      chk("m_cpu_rd", bus.cpu_rd, m_rd);
      chk("m_hwint", 32'(hwint), 32'(m_hw));
    end
  end

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int lat);
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = we;
    bus.cpu_addr = addr;
    bus.cpu_wd   = wd;
    lat = -1;
    rd  = 'x;
    err = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.cpu_ack) begin
        lat = i;
        rd  = bus.cpu_rd;
        err = bus.cpu_err;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          acks;
    int          ack_pos;

    bus.cpu_req  = 1'b0;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wd   = '0;
    irq_in       = '0;
    dev0_rd      = 32'hA5A5_0001;
    dev1_rd      = 32'h0000_0007;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset_ack", bus.cpu_ack, 0);
    chk("reset_dev_addr", dev_addr, 0);
    chk("reset_hwint", 32'(hwint), 0);
    chk("reset_cpu_rd", bus.cpu_rd, 0);

    // Reset during the ACCESS cycle of a write to timer 0.
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = 32'h0000_7F04;
    bus.cpu_wd   = 32'h0000_0010;
    @(negedge clk);
    chk("rst_mid_we0_high", dev0_we, 1);
    #1;
    reset_n     = 1'b0;
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    #1;
    chk("rst_mid_we0_drop", dev0_we, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_no_ack", bus.cpu_ack, 0);
    end
    reset_n = 1'b1;
    #1;
    chk("rst_rel_dev_addr", dev_addr, 0);
    chk("rst_rel_dev_wd", dev_wd, 0);
    chk("rst_rel_we0", dev0_we, 0);
    chk("rst_rel_hwint", 32'(hwint), 0);
    access(1'b0, 32'h0000_7F20, 32'h0, rd, err, lat);
    chk("rst_mask_read", rd, 32'h3F);
    chk("rst_mask_lat", lat, 2);

    // Write to timer 0: strobe for one cycle, ack two cycles after the drive.
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = 32'h0000_7F04;
    bus.cpu_wd   = 32'h0000_0010;
    @(negedge clk);
    chk("wr_we0", dev0_we, 1);
    chk("wr_we1", dev1_we, 0);
    chk("wr_dev_addr", dev_addr, 32'h0000_7F04);
    chk("wr_dev_wd", dev_wd, 32'h0000_0010);
    @(negedge clk);
    chk("wr_ack", bus.cpu_ack, 1);
    chk("wr_we0_gone", dev0_we, 0);
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;

    // Read timer 1: data held after the ack.
    access(1'b0, 32'h0000_7F18, 32'h0, rd, err, lat);
    chk("rd1_data", rd, 32'h7);
    chk("rd1_lat", lat, 2);
    chk("rd1_dev_addr", dev_addr, 32'h0000_7F18);
    repeat (2) @(negedge clk);
    chk("rd1_held", bus.cpu_rd, 32'h7);

    // Mask write and raw irq readback.
    irq_in = 6'b000011;
    repeat (2) @(negedge clk);
    chk("irq_hw_before", 32'(hwint), 32'h3);
    access(1'b1, 32'h0000_7F20, 32'h2, rd, err, lat);
    chk("mask_wr_lat", lat, 2);
    @(negedge clk);
    chk("irq_hw_after", 32'(hwint), 32'h2);
    access(1'b0, 32'h0000_7F24, 32'h0, rd, err, lat);
    chk("irq_raw_read", rd, 32'h3);
    access(1'b0, 32'h0000_7F20, 32'h0, rd, err, lat);
    chk("mask_readback", rd, 32'h2);

    // Unmapped accesses.
    access(1'b0, 32'h0000_7F40, 32'h0, rd, err, lat);
    chk("unmap_rd", rd, 32'h0);
    chk("unmap_lat", lat, 2);
    chk("unmap_err", err, 32'(BUSERR));
    access(1'b1, 32'h0000_7F44, 32'hDEAD_BEEF, rd, err, lat);
    chk("unmap_wr_err", err, 32'(BUSERR));

    // Miscellaneous local and device traffic.
    access(1'b1, 32'h0000_7F24, 32'h0, rd, err, lat);
    access(1'b0, 32'h0000_7F24, 32'h0, rd, err, lat);
    chk("raw_wr_ignored", rd, 32'h3);
    access(1'b0, 32'h0000_7F2C, 32'h0, rd, err, lat);
    chk("local_c_zero", rd, 32'h0);
    access(1'b1, 32'h0000_7F1C, 32'h0000_1234, rd, err, lat);
    chk("wr_dev1_lat", lat, 2);
    access(1'b0, 32'h0000_7F0C, 32'h0, rd, err, lat);
    chk("rd0_data", rd, 32'hA5A5_0001);
    access(1'b1, 32'h0000_7F20, 32'h3F, rd, err, lat);

    // Request held high for nine sampling edges.
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h0000_7F10;
    acks    = 0;
    ack_pos = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (bus.cpu_ack) begin
        acks++;
        ack_pos = ack_pos | (1 << i);
      end
      if (i == 9) bus.cpu_req = 1'b0;
    end
    chk("held_ack_count", acks, 3);
    chk("held_ack_pos", ack_pos, 32'h124);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
